ahb_slave_mem: RTL and testbench

//   AHB-lite slave responder: the far end of the address decoder's hsel_N outputs.
//   It sits on one select line (slave0/1/2) and serves a word-organised register-array memory.
//   It follows the standard AHB-lite address/data pipeline, with programmable wait states and

---
 rtl/ahb_slave_mem.sv | 220 ++++++++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// Purpose : AHB-lite slave serving a word-organised register-array memory behind one hsel line.
// Latency : OKAY data phase = WAIT_STATES+1 cycles; ERROR response = 2 cycles (ERR1, ERR2).
// Backpressure: stalls the bus by dropping hreadyout in WAIT/ERR1; new address phases are
//               taken only when hready is high and this slave is in a ready state.
//
// Ports:
//   hclk       bus clock, all state on the rising edge
//   hreset     synchronous active-high reset (memory array itself is not cleared)
//   hsel       slave select from the address decoder
//   haddr      byte address; [DEPTH_LOG2+1:2] is the word index, [13:DEPTH_LOG2+2] must be 0
//   htrans     transfer type; only NONSEQ/SEQ (htrans[1]=1) start an access
//   hwrite     1 = write, 0 = read
//   hsize      000 byte, 001 halfword, 010 word; anything larger is answered with ERROR
//   hwdata     write data, sampled at the closing edge of the write's DONE cycle
//   hready     bus-wide ready from the response mux
//   hreadyout  this slave's ready
//   hresp      0 OKAY, 1 ERROR
//   hrdata     read data, valid in the final data-phase cycle of a read and held afterwards
module ahb_slave_mem #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [15:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Address bits between the top of the memory window and bit 13 must be zero.
  // Bits 15:14 belong to the decoder and are ignored here.
  localparam logic [15:0] WIN_MASK = 16'h3FFF & ~((16'd1 << (DEPTH_LOG2 + 2)) - 16'd1);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Everything about the transfer that must survive from address phase to data phase.
  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
    logic                  write;
    logic [3:0]            be;
  } req_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  req_t        req_q;
  req_t        req_d;
  logic [31:0] hrdata_q;
  logic [31:0] mem [DEPTH];

  logic        can_accept;
  logic        accept;
  logic        size_bad;
  logic        misalign;
  logic        out_win;
  logic        illegal;
  logic [3:0]  be_d;
  logic        wr_done;
  logic        rd_done;

  // Decoder-owned address bits and the BUSY/IDLE distinction carry no meaning here.
  logic        unused_bits;
  assign unused_bits = ^{htrans[0], haddr[15:14]};

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------

  // Only states that drive hreadyout=1 can close a data phase and take a new address.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept     = can_accept & hsel & hready & htrans[1];

  always_comb begin
    size_bad = (hsize > 3'b010);
    misalign = ((hsize == 3'b001) && haddr[0]) ||
               ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
    out_win  = |(haddr & WIN_MASK);
    illegal  = size_bad | misalign | out_win;
  end

  // Little-endian byte lanes selected by the low address bits.
  always_comb begin
    be_d = 4'b0000;
    case (hsize)
      3'b000:  be_d = 4'b0001 << haddr[1:0];
      3'b001:  be_d = haddr[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  always_comb begin
    req_d.idx   = haddr[DEPTH_LOG2+1:2];
    req_d.write = hwrite;
    req_d.be    = be_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= req_d;
      end
      // Capture uses the transfer closing now; a pipelined accept replaces req_q at the same edge.
      if (rd_done) begin
        hrdata_q <= mem[req_q.idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // cnt counts the remaining wait cycles including the current one.
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = hrdata_q;
    case (state_q)
      ST_WAIT: begin
        hreadyout = 1'b0;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: begin
        hresp = 1'b1;
      end
      ST_DONE: begin
        // Array read is combinational so a write committed at the previous edge is visible.
        if (!req_q.write) begin
          hrdata = mem[req_q.idx];
        end
      end
      default: begin
      end
    endcase
  end

  assign wr_done = (state_q == ST_DONE) &&  req_q.write;
  assign rd_done = (state_q == ST_DONE) && !req_q.write;

  // ---------------------------------------------------------------------------
  // Memory array (contents survive reset; a reset edge cancels the closing write)
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (!hreset && wr_done) begin
      for (int b = 0; b < 4; b++) begin
        if (req_q.be[b]) begin
          mem[req_q.idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
`timescale 1ns/1ps
module tb_ahb_slave_mem;

  localparam int NDUT = 3;   // instances with WAIT_STATES 0, 2, 3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset_a    [NDUT];
  logic        hsel_a      [NDUT];
  logic [15:0] haddr_a     [NDUT];
  logic [1:0]  htrans_a    [NDUT];
  logic        hwrite_a    [NDUT];
  logic [2:0]  hsize_a     [NDUT];
  logic [31:0] hwdata_a    [NDUT];
  logic        hready_a    [NDUT];
  logic        hreadyout_a [NDUT];
  logic        hresp_a     [NDUT];
  logic [31:0] hrdata_a    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign hready_a[g] = hreadyout_a[g];
    ahb_slave_mem #(
      .DEPTH_LOG2 (8),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .hclk     (clk),
      .hreset   (hreset_a[g]),
      .hsel     (hsel_a[g]),
      .haddr    (haddr_a[g]),
      .htrans   (htrans_a[g]),
      .hwrite   (hwrite_a[g]),
      .hsize    (hsize_a[g]),
      .hwdata   (hwdata_a[g]),
      .hready   (hready_a[g]),
      .hreadyout(hreadyout_a[g]),
      .hresp    (hresp_a[g]),
      .hrdata   (hrdata_a[g])
    );
  end

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  // Reference model: byte-addressed view of each slave's 1 KiB window plus last read data.
  logic [31:0] mem_m   [NDUT][256];
  logic [31:0] rdata_m [NDUT];
  xfer_t       q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) % 1024) / 4;
  endfunction

  function automatic bit is_illegal(input xfer_t t);
    if (t.size > 3'd2) return 1'b1;
    if (t.size == 3'd1 && (int'(t.addr) % 2) != 0) return 1'b1;
    if (t.size == 3'd2 && (int'(t.addr) % 4) != 0) return 1'b1;
    if ((int'(t.addr) % 16384) >= 1024) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_commit(input int d, input xfer_t t);
    int w;
    int first;
    int nbytes;
    w      = word_of(t.addr);
    first  = int'(t.addr) % 4;
    nbytes = 1 << t.size;
    for (int b = first; b < first + nbytes; b++) begin
      mem_m[d][w][8*b +: 8] = t.wdata[8*b +: 8];
    end
  endtask

  task automatic push(input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [15:0] a, input logic [2:0] sz, input logic [31:0] wd);
    xfer_t t;
    t.sel = sel; t.trans = tr; t.write = wr; t.addr = a; t.size = sz; t.wdata = wd;
    q.push_back(t);
  endtask

  task automatic drive_addr(input int d, input int ap);
    if (ap < q.size()) begin
      hsel_a[d]   = q[ap].sel;
      htrans_a[d] = q[ap].trans;
      hwrite_a[d] = q[ap].write;
      haddr_a[d]  = q[ap].addr;
      hsize_a[d]  = q[ap].size;
    end else begin
      hsel_a[d]   = 1'b0;
      htrans_a[d] = 2'b00;
      hwrite_a[d] = 1'b0;
      haddr_a[d]  = 16'($urandom);
      hsize_a[d]  = 3'd0;
    end
  endtask

  // Plays the queued transfers on slave d as a pipelined AHB master and checks every cycle.
  task automatic run_seq(input int d, input string tag);
    int    ap;
    int    dp;
    int    dcyc;
    int    cyc;
    int    ws;
    bit    rdy;
    bit    bad;
    bit    rd_final;
    xfer_t cur;
    ap = 0; dp = -1; dcyc = 0; cyc = 0; ws = ws_of(d); bad = 1'b0; cur = '0;
    @(posedge clk); #1;
    drive_addr(d, ap);
    forever begin
      @(negedge clk);
      cyc++;
      rdy      = hreadyout_a[d];
      rd_final = 1'b0;
      if (dp < 0) begin
        check({tag, " ready idle"}, 32'(rdy), 32'd1);
        check({tag, " resp idle"}, 32'(hresp_a[d]), 32'd0);
      end else begin
        dcyc++;
        if (bad) begin
          check({tag, " err resp"}, 32'(hresp_a[d]), 32'd1);
          check({tag, " err ready"}, 32'(rdy), 32'(dcyc == 2));
        end else begin
          check({tag, " ok resp"}, 32'(hresp_a[d]), 32'd0);
          check({tag, " ok ready"}, 32'(rdy), 32'(dcyc == ws + 1));
          rd_final = rdy && !cur.write;
        end
      end
      if (rd_final) check({tag, " read data"}, hrdata_a[d], mem_m[d][word_of(cur.addr)]);
      else          check({tag, " hrdata hold"}, hrdata_a[d], rdata_m[d]);
      if (cyc > 4000) begin
        check({tag, " cycle budget"}, 32'(cyc), 32'd4000);
        q.delete();
        return;
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (dp >= 0 && !bad) begin
          if (cur.write) model_commit(d, cur);
          else           rdata_m[d] = mem_m[d][word_of(cur.addr)];
        end
        if (ap < q.size() && q[ap].sel && q[ap].trans[1]) begin
          cur = q[ap];
          dp  = ap;
          bad = is_illegal(cur);
        end else begin
          dp = -1;
        end
        hwdata_a[d] = (dp >= 0) ? cur.wdata : $urandom;
        dcyc = 0;
        if (ap < q.size()) ap++;
        drive_addr(d, ap);
        if (ap >= q.size() && dp < 0) break;
      end
    end
    q.delete();
  endtask

  task automatic push_random(input int n);
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [15:0] a;
    int          r;
    for (int i = 0; i < n; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = 16'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 16'($urandom_range(1, 3));
      else if (sz == 3'd0)           a = a + 16'($urandom_range(0, 3));
      else if (sz == 3'd1)           a = a + 16'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 11) == 0) a = a | 16'($urandom_range(1, 15) << 10);
      a = a | 16'($urandom_range(0, 3) << 14);
      r  = $urandom_range(0, 7);
      tr = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : {1'b1, r[0]});
      push($urandom_range(0, 9) != 0, tr, $urandom_range(0, 1) == 1, a, sz, $urandom);
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      hreset_a[d] = 1'b1; hsel_a[d] = 1'b0; haddr_a[d] = '0; htrans_a[d] = 2'b00;
      hwrite_a[d] = 1'b0; hsize_a[d] = '0; hwdata_a[d] = '0; rdata_m[d] = '0;
    end

    // Reset for three cycles, then every slave must idle with OKAY and zero read data.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) hreset_a[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("reset hreadyout", 32'(hreadyout_a[d]), 32'd1);
      check("reset hresp", 32'(hresp_a[d]), 32'd0);
      check("reset hrdata", hrdata_a[d], 32'd0);
    end

    // IDLE/BUSY with hsel=1 and NONSEQ with hsel=0 must not start anything.
    for (int d = 0; d < NDUT; d++) begin
      push(1'b1, 2'b00, 1'b1, 16'h0010, 3'd2, 32'hFFFF_FFFF);
      push(1'b1, 2'b01, 1'b1, 16'h0010, 3'd2, 32'hFFFF_FFFF);
      push(1'b0, 2'b10, 1'b1, 16'h0010, 3'd2, 32'hFFFF_FFFF);
      run_seq(d, "idle");
    end

    // Give the 16 test words defined contents.
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 16; w++) push(1'b1, (w == 0) ? 2'b10 : 2'b11, 1'b1, 16'(w * 4), 3'd2, $urandom);
      run_seq(d, "preload");
    end

    // Zero wait states: write then pipelined read of the same word.
    push(1'b1, 2'b10, 1'b1, 16'h0010, 3'd2, 32'hDEAD_BEEF);
    push(1'b1, 2'b11, 1'b0, 16'h0010, 3'd2, 32'h0);
    run_seq(0, "ws0 wr-rd");
    @(negedge clk);
    check("ws0 deadbeef", hrdata_a[0], 32'hDEAD_BEEF);

    // Two wait states: single read, then NONSEQ/SEQ back to back.
    push(1'b1, 2'b10, 1'b0, 16'h0010, 3'd2, 32'h0);
    push(1'b0, 2'b00, 1'b0, 16'h0000, 3'd0, 32'h0);
    push(1'b1, 2'b10, 1'b0, 16'h0010, 3'd2, 32'h0);
    push(1'b1, 2'b11, 1'b0, 16'h0014, 3'd2, 32'h0);
    run_seq(1, "ws2 reads");

    // Mixed-size writes into one word.
    push(1'b1, 2'b10, 1'b1, 16'h0020, 3'd2, 32'h0000_0000);
    push(1'b1, 2'b10, 1'b1, 16'h0022, 3'd0, 32'h00AA_0000);
    push(1'b1, 2'b10, 1'b1, 16'h0020, 3'd1, 32'h0000_1234);
    push(1'b1, 2'b10, 1'b0, 16'h0020, 3'd2, 32'h0);
    run_seq(1, "lanes");
    @(negedge clk);
    check("lanes merged", hrdata_a[1], 32'h00AA_1234);

    // Misaligned halfword, bad size and out-of-window address all answer ERROR.
    push(1'b1, 2'b10, 1'b0, 16'h0021, 3'd1, 32'h0);
    push(1'b1, 2'b10, 1'b1, 16'h0024, 3'd3, 32'hCAFE_F00D);
    push(1'b1, 2'b10, 1'b0, 16'h3000, 3'd2, 32'h0);
    run_seq(1, "errors");
    @(negedge clk);
    check("errors hrdata kept", hrdata_a[1], 32'h00AA_1234);
    push(1'b1, 2'b10, 1'b0, 16'h0024, 3'd2, 32'h0);
    push(1'b1, 2'b10, 1'b0, 16'h0020, 3'd2, 32'h0);
    run_seq(1, "errors readback");
    @(negedge clk);
    check("errors mem kept", hrdata_a[1], 32'h00AA_1234);

    // Reset in the second wait cycle of a write (WAIT_STATES=3) drops the write.
    push(1'b1, 2'b10, 1'b1, 16'h0030, 3'd2, 32'h1122_3344);
    run_seq(2, "rst setup");
    hsel_a[2] = 1'b1; htrans_a[2] = 2'b10; hwrite_a[2] = 1'b1; haddr_a[2] = 16'h0030; hsize_a[2] = 3'd0;
    @(posedge clk); #1;
    hwdata_a[2] = 32'h0000_0055; hsel_a[2] = 1'b0; htrans_a[2] = 2'b00;
    @(negedge clk);
    check("rst wait1 ready", 32'(hreadyout_a[2]), 32'd0);
    @(posedge clk); #1;
    hreset_a[2] = 1'b1;
    @(negedge clk);
    check("rst wait2 ready", 32'(hreadyout_a[2]), 32'd0);
    @(posedge clk); #1;
    hreset_a[2] = 1'b0;
    rdata_m[2]  = 32'h0;
    @(negedge clk);
    check("rst after ready", 32'(hreadyout_a[2]), 32'd1);
    check("rst after resp", 32'(hresp_a[2]), 32'd0);
    check("rst after hrdata", hrdata_a[2], 32'd0);
    push(1'b1, 2'b10, 1'b0, 16'h0030, 3'd2, 32'h0);
    run_seq(2, "rst readback");
    @(negedge clk);
    check("rst old value", hrdata_a[2], 32'h1122_3344);

    // Randomised traffic, then a full read sweep of the test words.
    for (int d = 0; d < NDUT; d++) begin
      push_random(120);
      run_seq(d, "random");
      for (int w = 0; w < 16; w++) push(1'b1, 2'b10, 1'b0, 16'(w * 4), 3'd2, 32'h0);
      run_seq(d, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
